// File: rtl/n64_read_response.sv
// N64 controller status-response receiver: decodes 32 pulse-width bits MSB-first,
// strobes the assembled word, and aborts with a timeout pulse on a silent or stuck line.
`timescale 1ns/1ps
module n64_read_response #(
  parameter int BIT_SAMPLE = 200,
  parameter int TIMEOUT    = 1000,
  parameter int NUM_BITS   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                begin_read,
  input  logic                data_in,
  output logic                reading_data,
  output logic [NUM_BITS-1:0] button_data,
  output logic                data_valid,
  output logic                timeout_err,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FALL = 3'd1,
    SAMPLE    = 3'd2,
    WAIT_RISE = 3'd3,
    STOP_LOW  = 3'd4
  } state_e;

  localparam int IW = $clog2(NUM_BITS + 1);
  // Compare against the pre-increment count, so each wait lasts exactly N cycles.
  localparam logic [15:0]   SAMPLE_LAST = 16'(BIT_SAMPLE - 1);
  localparam logic [15:0]   WAIT_LAST   = 16'(TIMEOUT - 1);
  localparam logic [15:0]   RISE_LAST   = 16'(BIT_SAMPLE + TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_BITS);

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NUM_BITS-1:0] shreg_q, shreg_d;
  logic [NUM_BITS-1:0] button_q, button_d;
  logic                valid_q, valid_d;
  logic                tout_q, tout_d;
  logic                sync1_q, line_s_q, line_d_q;
  logic                fall, rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      line_s_q <= 1'b1;
      line_d_q <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      button_q <= '0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      sync1_q  <= data_in;
      line_s_q <= sync1_q;
      line_d_q <= line_s_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      button_q <= button_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
    end
  end

  assign fall = line_d_q & ~line_s_q;
  assign rise = ~line_d_q & line_s_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    button_d = button_q;
    valid_d  = 1'b0;
    tout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (begin_read) begin
          state_d = WAIT_FALL;
          cnt_d   = '0;
          idx_d   = '0;
          shreg_d = '0;
        end
      end
      WAIT_FALL: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = (idx_q == IDX_LAST) ? STOP_LOW : SAMPLE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = IDLE;
          tout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SAMPLE: begin
        // Edges during the low pulse are ignored; only the sample point matters.
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == SAMPLE_LAST) begin
          shreg_d = {shreg_q[NUM_BITS-2:0], line_s_q};
          idx_d   = idx_q + IW'(1);
          if (line_s_q) begin
            state_d = WAIT_FALL;
            cnt_d   = '0;
          end else begin
            state_d = WAIT_RISE;
          end
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          state_d = WAIT_FALL;
          cnt_d   = '0;
        end else if (cnt_q == RISE_LAST) begin
          state_d = IDLE;
          tout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP_LOW: begin
        if (rise) begin
          button_d = shreg_q;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = IDLE;
          tout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign reading_data = (state_q != IDLE);
  assign button_data  = button_q;
  assign data_valid   = valid_q;
  assign timeout_err  = tout_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_n64_read_response.sv
// Directed bench for n64_read_response: drivers push expected words/strobe times,
// a negedge monitor pops and compares whenever a strobe appears.
`timescale 1ns/1ps
module tb_n64_read_response;
  localparam int BIT_SAMPLE = 200;
  localparam int TIMEOUT    = 1000;
  localparam int W          = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         begin_read = 1'b0;
  logic         data_in = 1'b1;
  logic         reading_data;
  logic [W-1:0] button_data;
  logic         data_valid;
  logic         timeout_err;
  logic [2:0]   dbg_state;

  n64_read_response #(.BIT_SAMPLE(BIT_SAMPLE), .TIMEOUT(TIMEOUT), .NUM_BITS(W)) dut (
    .clk(clk), .rst(rst), .begin_read(begin_read), .data_in(data_in),
    .reading_data(reading_data), .button_data(button_data),
    .data_valid(data_valid), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // Clock / cycle counter / watchdog
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int           exp_vc_q[$];
  int           exp_to_q[$];
  logic [W-1:0] exp_button = '0;
  logic         prev_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      check("strobe_overlap", 64'(data_valid & timeout_err), 64'd0);
      if (prev_valid) begin
        check("valid_width", 64'(data_valid), 64'd0);
        check("reading_after_valid", 64'(reading_data), 64'd0);
      end
      if (data_valid) begin
        check("valid_expected", 64'(exp_q.size() > 0 && exp_vc_q.size() > 0), 64'd1);
        if (exp_q.size() > 0 && exp_vc_q.size() > 0) begin
          logic [W-1:0] w;
          int           vc;
          w  = exp_q.pop_front();
          vc = exp_vc_q.pop_front();
          check("button_word", 64'(button_data), 64'(w));
          check("valid_cycle", 64'(cyc), 64'(vc));
          exp_button = w;
        end
      end else begin
        check("button_hold", 64'(button_data), 64'(exp_button));
      end
      if (timeout_err) begin
        check("timeout_expected", 64'(exp_to_q.size() > 0), 64'd1);
        if (exp_to_q.size() > 0) begin
          int tc;
          tc = exp_to_q.pop_front();
          check("timeout_cycle", 64'(cyc), 64'(tc));
        end
      end
      prev_valid = data_valid;
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_begin(output int kb);
    kb = cyc;
    begin_read = 1'b1;
    tick(1);
    begin_read = 1'b0;
    check("reading_rise", 64'(reading_data), 64'd1);
  endtask

  // 1 = 100 low / 300 high, 0 = 300 low / 100 high; optional stray begin_read during the low.
  task automatic drive_bit(input logic b, input logic inject);
    int low;
    low = b ? 100 : 300;
    data_in = 1'b0;
    if (inject) begin
      begin_read = 1'b1;
      tick(1);
      begin_read = 1'b0;
      tick(low - 1);
    end else begin
      tick(low);
    end
    data_in = 1'b1;
    tick(b ? 300 : 100);
  endtask

  task automatic drive_frame(input logic [W-1:0] w, input int inject_bit);
    int kb;
    exp_q.push_back(w);
    pulse_begin(kb);
    tick(10);
    for (int i = 0; i < W; i++) drive_bit(w[W-1-i], i == inject_bit);
    data_in = 1'b0;
    tick(200);
    data_in = 1'b1;
    exp_vc_q.push_back(cyc + 3);
    tick(20);
  endtask

  // Stimulus
  initial begin
    int           kb;
    logic [4:0]   pat5;
    logic [W-1:0] wr;

    tick(2);
    check("rst_reading", 64'(reading_data), 64'd0);
    check("rst_button", 64'(button_data), 64'd0);
    check("rst_valid", 64'(data_valid), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    tick(3);
    rst = 1'b0;

    tick(50);
    check("idle_reading", 64'(reading_data), 64'd0);
    check("idle_valid", 64'(data_valid), 64'd0);
    check("idle_timeout", 64'(timeout_err), 64'd0);
    check("idle_line_s", 64'(dut.line_s_q), 64'd1);

    drive_frame(32'h8001_4A3C, -1);
    check("frame1_idle", 64'(reading_data), 64'd0);

    // No controller: line stays high
    pulse_begin(kb);
    exp_to_q.push_back(kb + 1 + TIMEOUT);
    tick(TIMEOUT + 20);
    check("noctl_reading", 64'(reading_data), 64'd0);
    check("noctl_button", 64'(button_data), 64'h8001_4A3C);

    // Line stuck low after five good bits
    pulse_begin(kb);
    tick(10);
    pat5 = 5'b10110;
    for (int i = 0; i < 5; i++) drive_bit(pat5[4-i], 1'b0);
    data_in = 1'b0;
    exp_to_q.push_back(cyc + 3 + BIT_SAMPLE + TIMEOUT);
    tick(BIT_SAMPLE + TIMEOUT + 20);
    check("stuck_reading", 64'(reading_data), 64'd0);
    check("stuck_button", 64'(button_data), 64'h8001_4A3C);
    data_in = 1'b1;
    tick(20);

    // Reset during bit 17
    wr = 32'h1357_9BDF;
    pulse_begin(kb);
    tick(10);
    for (int i = 0; i < 17; i++) drive_bit(wr[W-1-i], 1'b0);
    data_in = 1'b0;
    tick(50);
    rst = 1'b1;
    tick(1);
    check("midrst_reading", 64'(reading_data), 64'd0);
    check("midrst_button", 64'(button_data), 64'd0);
    check("midrst_valid", 64'(data_valid), 64'd0);
    check("midrst_timeout", 64'(timeout_err), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    exp_button = '0;
    data_in = 1'b1;
    tick(20);

    drive_frame(32'hA5C3_0F96, -1);
    drive_frame(32'hFFFF_FFFF, 10);
    drive_frame(32'h0000_0000, -1);

    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && exp_to_q.size() == 0) break;
      tick(1);
    end
    check("words_drained", 64'(exp_q.size()), 64'd0);
    check("timeouts_drained", 64'(exp_to_q.size()), 64'd0);
    check("final_button", 64'(button_data), 64'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
